// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the core memory stage and a
// byte-addressed data memory with a combinational read port.
// - Aligned accesses are issued as a single memory cycle.
// - Misaligned halfword/word accesses are either split into byte cycles
//   or rejected with resp_err, depending on SPLIT_EN.
// - Every completion, including errors, is reported by a one-cycle
//   registered resp_valid pulse.
module lsu_mem_ctrl #(
  parameter bit          SPLIT_EN  = 1'b1,
  parameter logic [31:0] BASE_MASK = 32'h0FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wData,
  output logic [2:0]  mem_size,
  output logic        mem_wEn,
  input  logic [31:0] mem_rData
);

  // funct3 size encodings, shared by the request and memory ports
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_SPLIT,
    S_RESP
  } state_t;

  state_t      state;

  // Captured request
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Split access bookkeeping: current byte index, final byte index and
  // the little-endian load assembly buffer
  logic [1:0]  k_q;
  logic [1:0]  k_last_q;
  logic [31:0] asm_q;

  // Request decode
  logic        req_legal;
  logic        req_misal;
  logic        req_go_err;
  logic        req_go_split;
  logic [1:0]  req_k_last;

  // Split datapath
  logic [1:0]  k_next;
  logic [31:0] split_addr_next;
  logic [7:0]  wbyte_next;
  logic [31:0] asm_cur;
  logic [31:0] split_rdata;

  // Classify the incoming request: legal size, alignment and route
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    req_legal    = 1'b0;
    req_misal    = 1'b0;
    req_k_last   = 2'd1;
    req_go_err   = 1'b0;
    req_go_split = 1'b0;

    case (req_size)
      SZ_B, SZ_H, SZ_W: req_legal = 1'b1;
      SZ_BU, SZ_HU:     req_legal = !req_we;
      default:          req_legal = 1'b0;
    endcase

    // Only halfword (x01) and word (010) sizes can be misaligned; other
    // x10 codes are already illegal.
    case (req_size[1:0])
      2'b01:   req_misal = req_addr[0];
      2'b10:   req_misal = |req_addr[1:0];
      default: req_misal = 1'b0;
    endcase

    if (req_size[1:0] == 2'b10) req_k_last = 2'd3;

    req_go_err   = !req_legal || (req_misal && !SPLIT_EN);
    req_go_split = req_legal && req_misal && SPLIT_EN;
  end

  // Next byte of a split access and the load value assembled so far
  always_comb begin
    k_next          = k_q + 2'd1;
    split_addr_next = (addr_q + {30'd0, k_next}) & BASE_MASK;

    case (k_next)
      2'd0:    wbyte_next = wdata_q[7:0];
      2'd1:    wbyte_next = wdata_q[15:8];
      2'd2:    wbyte_next = wdata_q[23:16];
      default: wbyte_next = wdata_q[31:24];
    endcase

    // Merge the byte returned this cycle into the assembly buffer
    asm_cur = asm_q;
    case (k_q)
      2'd0:    asm_cur[7:0]   = mem_rData[7:0];
      2'd1:    asm_cur[15:8]  = mem_rData[7:0];
      2'd2:    asm_cur[23:16] = mem_rData[7:0];
      default: asm_cur[31:24] = mem_rData[7:0];
    endcase

    // Only H/HU/W reach the split path; size bit 2 selects zero extension
    if (k_last_q == 2'd3) begin
      split_rdata = asm_cur;
    end else if (size_q[2]) begin
      split_rdata = {16'd0, asm_cur[15:0]};
    end else begin
      split_rdata = {{16{asm_cur[15]}}, asm_cur[15:0]};
    end
  end

  // Control FSM; all handshake and memory-port outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wData  <= 32'd0;
      mem_size   <= SZ_BU;
      mem_wEn    <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      k_q        <= 2'd0;
      k_last_q   <= 2'd0;
      asm_q      <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so these
      // idle defaults are safely overridden by the state-specific ones below.
      resp_valid <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wData  <= 32'd0;
      mem_size   <= SZ_BU;
      mem_wEn    <= 1'b0;

      case (state)
        S_IDLE: begin
          // Ready rises one cycle after reset release and stays up in IDLE
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            size_q    <= req_size;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            k_q       <= 2'd0;
            k_last_q  <= req_k_last;
            asm_q     <= 32'd0;
            if (req_go_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (req_go_split) begin
              // Byte 0 of the split access goes out immediately
              state     <= S_SPLIT;
              mem_addr  <= req_addr & BASE_MASK;
              mem_size  <= req_we ? SZ_B : SZ_BU;
              mem_wData <= {24'd0, req_wdata[7:0]};
              mem_wEn   <= req_we;
            end else begin
              state     <= S_ACC;
              mem_addr  <= req_addr & BASE_MASK;
              mem_size  <= req_size;
              mem_wData <= req_wdata;
              mem_wEn   <= req_we;
            end
          end
        end

        S_ACC: begin
          // The memory already extends the load, so take rData as-is
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= we_q ? 32'd0 : mem_rData;
        end

        S_SPLIT: begin
          asm_q <= asm_cur;
          if (k_q == k_last_q) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'd0 : split_rdata;
          end else begin
            k_q       <= k_next;
            mem_addr  <= split_addr_next;
            mem_size  <= we_q ? SZ_B : SZ_BU;
            mem_wData <= {24'd0, wbyte_next};
            mem_wEn   <= we_q;
          end
        end

        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed test of lsu_mem_ctrl with a byte-array data
// memory model. dut1 splits misaligned accesses, dut0 rejects them.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        valid1, ready1, rv1, err1, wen1;
  logic [31:0] rdata1, maddr1, mwdata1, mrdata1;
  logic [2:0]  msize1;

  logic        valid0, ready0, rv0, err0, wen0;
  logic [31:0] rdata0, maddr0, mwdata0, mrdata0;
  logic [2:0]  msize0;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_ctrl #(.SPLIT_EN(1'b1), .BASE_MASK(32'h0FFF_FFFF)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid1), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rdata1), .resp_err(err1),
    .mem_addr(maddr1), .mem_wData(mwdata1), .mem_size(msize1),
    .mem_wEn(wen1), .mem_rData(mrdata1)
  );

  lsu_mem_ctrl #(.SPLIT_EN(1'b0), .BASE_MASK(32'h0FFF_FFFF)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid0), .req_ready(ready0), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0),
    .mem_addr(maddr0), .mem_wData(mwdata0), .mem_size(msize0),
    .mem_wEn(wen0), .mem_rData(mrdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: 4 KiB window, combinational extended read
  bit [7:0] mem [0:4095];
  logic [11:0] a1, a0;
  assign a1 = maddr1[11:0];
  assign a0 = maddr0[11:0];

  function automatic logic [31:0] ext(input logic [2:0] s, input logic [31:0] w);
    case (s)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb mrdata1 = ext(msize1, {mem[a1 + 12'd3], mem[a1 + 12'd2], mem[a1 + 12'd1], mem[a1]});
  always_comb mrdata0 = ext(msize0, {mem[a0 + 12'd3], mem[a0 + 12'd2], mem[a0 + 12'd1], mem[a0]});

  // Memory write port plus a log of every write cycle
  int          wcnt1 = 0;
  int          wcnt0 = 0;
  logic [31:0] log_a [64];
  logic [31:0] log_d [64];
  logic [2:0]  log_s [64];

  always @(posedge clk) begin
    if (wen1) begin
      for (int i = 0; i < ((msize1 == 3'b000) ? 1 : (msize1 == 3'b001) ? 2 : 4); i++)
        mem[12'(a1 + i)] <= mwdata1[8*i +: 8];
      if (wcnt1 < 64) begin
        log_a[wcnt1] <= maddr1;
        log_d[wcnt1] <= mwdata1;
        log_s[wcnt1] <= msize1;
      end
      wcnt1 <= wcnt1 + 1;
    end
    if (wen0) wcnt0 <= wcnt0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on dut1 (d0=0) or dut0 (d0=1) and collect the response
  task automatic do_req(input string tag, input bit d0, input bit we, input logic [2:0] sz,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic [31:0] a_first);
    int guard;
    guard = 0;
    while (!(d0 ? ready0 : ready1) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_ready"}, {31'd0, d0 ? ready0 : ready1}, 32'd1);
    req_we = we; req_size = sz; req_addr = ad; req_wdata = wd;
    if (d0) valid0 = 1'b1; else valid1 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    req_addr = 32'hXXXX_XXXF;  // ignored while busy
    a_first = d0 ? maddr0 : maddr1;
    lat = 1;
    while (!(d0 ? rv0 : rv1) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = d0 ? rdata0 : rdata1;
    er = d0 ? err0 : err1;
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, d0 ? rv0 : rv1}, 32'd0);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout: observed no finish expected finish");
  end

  initial begin
    int          lat;
    logic [31:0] rd, af;
    logic        er;
    int          w0;

    rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
    req_we = 1'b0; req_size = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready1}, 32'd0);
    check("rst_resp_valid", {31'd0, rv1}, 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_err", {31'd0, err1}, 32'd0);
    check("rst_wen", {31'd0, wen1}, 32'd0);
    check("rst_addr", maddr1, 32'd0);
    check("rst_wdata", mwdata1, 32'd0);
    check("rst_size", {29'd0, msize1}, 32'd4);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", {31'd0, ready1}, 32'd0);
    @(posedge clk); #1;
    check("rel_ready_high", {31'd0, ready1}, 32'd1);

    // Aligned SW then LW
    w0 = wcnt1;
    do_req("sw_al", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, lat, rd, er, af);
    check("sw_al_lat", 32'(lat), 32'd2);
    check("sw_al_err", {31'd0, er}, 32'd0);
    check("sw_al_rdata", rd, 32'd0);
    check("sw_al_wcnt", 32'(wcnt1 - w0), 32'd1);
    check("sw_al_size", {29'd0, log_s[w0]}, 32'd2);
    check("sw_al_addr", log_a[w0], 32'h100);
    check("sw_al_data", log_d[w0], 32'hDEAD_BEEF);

    do_req("lw_al", 1'b0, 1'b0, 3'b010, 32'h100, 32'd0, lat, rd, er, af);
    check("lw_al_lat", 32'(lat), 32'd2);
    check("lw_al_rdata", rd, 32'hDEAD_BEEF);
    check("lw_al_err", {31'd0, er}, 32'd0);

    // Address window mask
    do_req("lw_mask", 1'b0, 1'b0, 3'b010, 32'hF000_0100, 32'd0, lat, rd, er, af);
    check("lw_mask_addr", af, 32'h0000_0100);
    check("lw_mask_rdata", rd, 32'hDEAD_BEEF);

    // No-split instance: misaligned rejected, aligned works
    w0 = wcnt0;
    do_req("d0_lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'd0, lat, rd, er, af);
    check("d0_lw_mis_lat", 32'(lat), 32'd1);
    check("d0_lw_mis_err", {31'd0, er}, 32'd1);
    check("d0_lw_mis_rdata", rd, 32'd0);
    check("d0_lw_mis_addr", af, 32'd0);
    check("d0_lw_mis_wcnt", 32'(wcnt0 - w0), 32'd0);
    do_req("d0_lw_al", 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, lat, rd, er, af);
    check("d0_lw_al_lat", 32'(lat), 32'd2);
    check("d0_lw_al_rdata", rd, 32'hDEAD_BEEF);
    check("d0_lw_al_err", {31'd0, er}, 32'd0);

    // Sign/zero extension: 0x80 @0x200, 0xFF @0x201
    do_req("sb0", 1'b0, 1'b1, 3'b000, 32'h200, 32'h1234_5680, lat, rd, er, af);
    do_req("sb1", 1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00FF, lat, rd, er, af);
    do_req("lb", 1'b0, 1'b0, 3'b000, 32'h200, 32'd0, lat, rd, er, af);
    check("lb_rdata", rd, 32'hFFFF_FF80);
    do_req("lbu", 1'b0, 1'b0, 3'b100, 32'h200, 32'd0, lat, rd, er, af);
    check("lbu_rdata", rd, 32'h0000_0080);
    do_req("lh", 1'b0, 1'b0, 3'b001, 32'h200, 32'd0, lat, rd, er, af);
    check("lh_rdata", rd, 32'hFFFF_FF80);
    do_req("lhu", 1'b0, 1'b0, 3'b101, 32'h200, 32'd0, lat, rd, er, af);
    check("lhu_rdata", rd, 32'h0000_FF80);

    // Illegal sizes: no write, memory unchanged
    w0 = wcnt1;
    do_req("st_ill", 1'b0, 1'b1, 3'b100, 32'h100, 32'h0, lat, rd, er, af);
    check("st_ill_lat", 32'(lat), 32'd1);
    check("st_ill_err", {31'd0, er}, 32'd1);
    check("st_ill_rdata", rd, 32'd0);
    do_req("ld_ill", 1'b0, 1'b0, 3'b011, 32'h100, 32'h0, lat, rd, er, af);
    check("ld_ill_err", {31'd0, er}, 32'd1);
    check("ld_ill_rdata", rd, 32'd0);
    check("ill_wcnt", 32'(wcnt1 - w0), 32'd0);
    do_req("lw_after_ill", 1'b0, 1'b0, 3'b010, 32'h100, 32'd0, lat, rd, er, af);
    check("lw_after_ill_rdata", rd, 32'hDEAD_BEEF);
    check("lw_after_ill_err", {31'd0, er}, 32'd0);

    // Misaligned split store and loads
    w0 = wcnt1;
    do_req("sw_mis", 1'b0, 1'b1, 3'b010, 32'h103, 32'h1122_3344, lat, rd, er, af);
    check("sw_mis_lat", 32'(lat), 32'd5);
    check("sw_mis_wcnt", 32'(wcnt1 - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_mis_addr%0d", i), log_a[w0 + i], 32'h103 + 32'(i));
      check($sformatf("sw_mis_data%0d", i), log_d[w0 + i], (32'h1122_3344 >> (8 * i)) & 32'hFF);
      check($sformatf("sw_mis_size%0d", i), {29'd0, log_s[w0 + i]}, 32'd0);
    end
    do_req("lw_mis", 1'b0, 1'b0, 3'b010, 32'h103, 32'd0, lat, rd, er, af);
    check("lw_mis_lat", 32'(lat), 32'd5);
    check("lw_mis_rdata", rd, 32'h1122_3344);
    do_req("lh_mis", 1'b0, 1'b0, 3'b001, 32'h105, 32'd0, lat, rd, er, af);
    check("lh_mis_lat", 32'(lat), 32'd3);
    check("lh_mis_rdata", rd, 32'h0000_1122);
    do_req("lh_mis_neg", 1'b0, 1'b0, 3'b001, 32'h1FF, 32'd0, lat, rd, er, af);
    check("lh_mis_neg_rdata", rd, 32'hFFFF_8000);
    do_req("lhu_mis", 1'b0, 1'b0, 3'b101, 32'h1FF, 32'd0, lat, rd, er, af);
    check("lhu_mis_rdata", rd, 32'h0000_8000);

    // Split address wraps mod 2^32 and is masked
    w0 = wcnt1;
    do_req("sw_wrap", 1'b0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4, lat, rd, er, af);
    check("sw_wrap_a0", log_a[w0], 32'h0FFF_FFFE);
    check("sw_wrap_a1", log_a[w0 + 1], 32'h0FFF_FFFF);
    check("sw_wrap_a2", log_a[w0 + 2], 32'h0000_0000);
    check("sw_wrap_a3", log_a[w0 + 3], 32'h0000_0001);
    do_req("lw_wrap", 1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, lat, rd, er, af);
    check("lw_wrap_rdata", rd, 32'hA1B2_C3D4);

    // Reset during the second byte of a split store
    w0 = wcnt1;
    req_we = 1'b1; req_size = 3'b010; req_addr = 32'h301; req_wdata = 32'h5566_7788;
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    check("rm_b0_wen", {31'd0, wen1}, 32'd1);
    check("rm_b0_data", mwdata1, 32'h88);
    @(posedge clk); #1;
    check("rm_b1_wen", {31'd0, wen1}, 32'd1);
    check("rm_b1_addr", maddr1, 32'h302);
    #2 rst_n = 1'b0;
    #1;
    check("rm_wen_drop", {31'd0, wen1}, 32'd0);
    check("rm_no_resp", {31'd0, rv1}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rm_ready", {31'd0, ready1}, 32'd1);
    check("rm_no_resp_after", {31'd0, rv1}, 32'd0);
    check("rm_wcnt", 32'(wcnt1 - w0), 32'd1);
    check("rm_mem301", {24'd0, mem[12'h301]}, 32'h88);
    check("rm_mem303", {24'd0, mem[12'h303]}, 32'h00);
    check("rm_mem304", {24'd0, mem[12'h304]}, 32'h00);
    do_req("rm_lw", 1'b0, 1'b0, 3'b010, 32'h300, 32'd0, lat, rd, er, af);
    check("rm_lw_rdata", rd, 32'h0000_8800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
